// File: rtl/store64_bswap.sv
`default_nettype none
// ============================================================================
//  Module   : store64_bswap
//  Purpose  : Converts one Keccak lane (integer view) into its little-endian
//             byte-array image. Byte arrays in the keccak datapath are packed
//             MSB-first (array byte 0 in the top byte), so the conversion is
//             a full byte reversal. The operation is its own inverse, so the
//             same block also serves as load64.
//  Ports    : i_clk    - clock, all state changes on the rising edge
//             i_rstn   - synchronous active-low reset
//             i_valid  - qualifies i_data this cycle
//             i_data   - lane value, BW_DATA bits
//             o_valid  - registered qualifier for o_data
//             o_data   - registered byte-reversed image of the captured lane
//  Params   : BW_DATA  - data width, nonzero multiple of 8 (default 64)
//  Revision : 1.0 - initial release
// ============================================================================
module store64_bswap #(
    parameter int BW_DATA = 64
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    input  logic [BW_DATA-1:0] i_data,
    output logic               o_valid,
    output logic [BW_DATA-1:0] o_data
);

    // BW_DATA must be a nonzero multiple of 8; any remainder bits would be
    // left undriven by the byte loop below.
    localparam int NB = BW_DATA / 8;

    logic [BW_DATA-1:0] w_data_d;
    logic [BW_DATA-1:0] r_data_q;
    logic               r_valid_q;

    // Output byte k takes input byte NB-1-k; bit order inside a byte is kept.
    // With NB == 1 this collapses to a straight wire.
    generate
        for (genvar k = 0; k < NB; k++) begin : g_byte
            assign w_data_d[8*k +: 8] = i_data[BW_DATA-8-8*k +: 8];
        end
    endgenerate

    // Reset wins over i_valid and drops anything in flight. Outside reset the
    // data register only loads on a valid beat, so o_data holds across idle
    // cycles while o_valid falls.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= i_valid;
            if (i_valid) begin
                r_data_q <= w_data_d;
            end
        end
    end

    assign o_valid = r_valid_q;
    assign o_data  = r_data_q;

endmodule
`default_nettype wire

// File: tb/tb_store64_bswap.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store64_bswap
//  Purpose  : Self-checking bench for store64_bswap. A 64-bit instance is
//             driven through reset, single, back-to-back, involution, random
//             and mid-stream reset cases; 16- and 8-bit instances cover the
//             narrow widths.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store64_bswap;

    logic        clk;
    logic        rstn;
    logic        i_valid;
    logic [63:0] i_data;
    logic        o_valid;
    logic [63:0] o_data;

    logic        v16;
    logic [15:0] d16;
    logic        ov16;
    logic [15:0] od16;

    logic        v8;
    logic [7:0]  d8;
    logic        ov8;
    logic [7:0]  od8;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_q[$];
    logic [63:0] m_data;
    logic        m_valid;

    store64_bswap #(.BW_DATA(64)) u_dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data)
    );

    store64_bswap #(.BW_DATA(16)) u_dut16 (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_valid (v16),
        .i_data  (d16),
        .o_valid (ov16),
        .o_data  (od16)
    );

    store64_bswap #(.BW_DATA(8)) u_dut8 (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_valid (v8),
        .i_data  (d8),
        .o_valid (ov8),
        .o_data  (od8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: reverse the byte order of a 64-bit lane.
    function automatic logic [63:0] bswap64(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = x[56-8*k +: 8];
        end
        return r;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock on the 64-bit instance. Expected images are queued when a
    // valid beat is driven outside reset and retired when o_valid shows up.
    task automatic drive(input logic r, input logic v, input logic [63:0] d);
        logic [63:0] exp;
        rstn    = r;
        i_valid = v;
        i_data  = d;
        if (r && v) sb_q.push_back(bswap64(d));
        @(posedge clk);
        #1;
        if (!r) begin
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            m_valid = v;
        end
        check_value("valid", {63'd0, o_valid}, {63'd0, m_valid});
        if (o_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_value("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp    = sb_q.pop_front();
                m_data = exp;
                check_value("data", o_data, exp);
            end
        end else begin
            check_value("data_hold", o_data, m_data);
        end
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] y;

        rstn    = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        v16     = 1'b0;
        d16     = '0;
        v8      = 1'b0;
        d8      = '0;
        m_valid = 1'b0;
        m_data  = '0;

        // Reset with a valid, all-ones input pending.
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check_value("rst_data", o_data, 64'd0);

        // Single transfer then idle: data must hold while valid drops.
        drive(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
        check_value("single", o_data, 64'hEFCD_AB89_6745_2301);
        drive(1'b1, 1'b0, 64'h0);
        check_value("idle_hold", o_data, 64'hEFCD_AB89_6745_2301);

        // Back-to-back beats.
        drive(1'b1, 1'b1, 64'h0000_0000_0000_0001);
        check_value("b2b0", o_data, 64'h0100_0000_0000_0000);
        drive(1'b1, 1'b1, 64'h8000_0000_0000_0000);
        check_value("b2b1", o_data, 64'h0000_0000_0000_0080);
        drive(1'b1, 1'b1, 64'h0000_0000_0000_00FF);
        check_value("b2b2", o_data, 64'hFF00_0000_0000_0000);

        // Involution on the known vector.
        drive(1'b1, 1'b1, 64'hEFCD_AB89_6745_2301);
        check_value("invol_known", o_data, 64'h0123_4567_89AB_CDEF);

        // Random involution: each pass checked against the model, the second
        // pass must also return the original.
        for (int n = 0; n < 100; n++) begin
            x = {$urandom(), $urandom()};
            drive(1'b1, 1'b1, x);
            y = o_data;
            drive(1'b1, 1'b1, y);
            check_value("invol_rand", o_data, x);
        end

        // Reset arrives together with a valid beat: it must be dropped.
        drive(1'b1, 1'b0, 64'h0);
        drive(1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        check_value("rst_mid", o_data, 64'd0);
        drive(1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D);
        check_value("after_rst", o_data, 64'h0DF0_FECA_EFBE_ADDE);
        drive(1'b1, 1'b0, 64'h0);

        // Narrow widths: nothing visible before the edge, result one edge later.
        v16 = 1'b1;
        d16 = 16'hA1B2;
        v8  = 1'b1;
        d8  = 8'h5C;
        #1;
        check_value("w16_pre", {63'd0, ov16}, 64'd0);
        check_value("w8_pre", {63'd0, ov8}, 64'd0);
        drive(1'b1, 1'b0, 64'h0);
        v16 = 1'b0;
        v8  = 1'b0;
        check_value("w16_valid", {63'd0, ov16}, 64'd1);
        check_value("w16_data", {48'd0, od16}, 64'h0000_0000_0000_B2A1);
        check_value("w8_valid", {63'd0, ov8}, 64'd1);
        check_value("w8_data", {56'd0, od8}, 64'h0000_0000_0000_005C);
        drive(1'b1, 1'b0, 64'h0);
        check_value("w16_idle", {63'd0, ov16}, 64'd0);
        check_value("w16_hold", {48'd0, od16}, 64'h0000_0000_0000_B2A1);

        check_value("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
